// File: rtl/counter_updn_prescale_pkg.sv
// counter_pkg: shared encodings for counter_updn_prescale.
//   DIR_UP / DIR_DOWN   : values of the dir input
//   MODE_WRAP / MODE_SAT: values of the mode input
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/ce_prescaler.sv
// ce_prescaler: divides enabled cycles by PRESCALE.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, clears progress
//   ce   - count enable; only ce=1 cycles advance the prescaler
//   clr  - synchronous clear; wins over ce and suppresses step
//   step - combinational: this cycle completes a prescale period
module ce_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic clr,
  output logic step
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    step  = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ce) begin
      if (cnt_q == LAST) begin
        step  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule : ce_prescaler

// File: rtl/counter_updn_prescale.sv
// counter_updn_prescale: up/down counter over 0..MAX with wrap or
// saturate boundary behaviour, stepped by a ce prescaler.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   ce   - count enable (feeds the prescaler)
//   dir  - 1 = up, 0 = down
//   mode - 0 = wrap, 1 = saturate
//   load - synchronous load of din (clamped to MAX), beats any step
//   din  - load value
//   q    - registered count
//   tick - registered: a step was taken on the previous edge
//   tc   - registered: the previous step wrapped (pulse with wrapped q)
//   sat  - registered: last step was blocked at a boundary in sat mode
module counter_updn_prescale
  import counter_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX      = 2**N - 1,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         dir,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] din,
  output logic [N-1:0] q,
  output logic         tick,
  output logic         tc,
  output logic         sat
);

  localparam logic [N-1:0] MAX_V = N'(MAX);

  logic         step;
  logic [N-1:0] q_q, q_d;
  logic         tick_q, tick_d;
  logic         tc_q, tc_d;
  logic         sat_q, sat_d;

  // load doubles as the prescaler clear, so a step is never reported
  // in a cycle where load wins.
  ce_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .clr (load),
    .step(step)
  );

  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    sat_d  = sat_q;
    if (load) begin
      q_d   = (din > MAX_V) ? MAX_V : din;
      sat_d = 1'b0;
    end else if (step) begin
      tick_d = 1'b1;
      if (dir == DIR_UP) begin
        if (q_q < MAX_V) begin
          q_d   = q_q + 1'b1;
          sat_d = 1'b0;
        end else if (mode == MODE_WRAP) begin
          q_d   = '0;
          tc_d  = 1'b1;
          sat_d = 1'b0;
        end else begin
          sat_d = 1'b1;
        end
      end else begin
        if (q_q != '0) begin
          q_d   = q_q - 1'b1;
          sat_d = 1'b0;
        end else if (mode == MODE_WRAP) begin
          q_d   = MAX_V;
          tc_d  = 1'b1;
          sat_d = 1'b0;
        end else begin
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
      sat_q  <= sat_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_q;
  assign tc   = tc_q;
  assign sat  = sat_q;

endmodule : counter_updn_prescale

// File: tb/tb_counter_updn_prescale.sv
// Bench for counter_updn_prescale: two instances (PRESCALE=1 and 3,
// N=3, MAX=5) share all inputs and are compared every cycle against
// a behavioural model, plus directed constant checks.
module tb_counter_updn_prescale;

  localparam int N    = 3;
  localparam int MAX  = 5;
  localparam int P0   = 1;
  localparam int P1   = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         ce, dir, mode, load;
  logic [N-1:0] din;
  logic [N-1:0] q0, q1;
  logic         tick0, tick1, tc0, tc1, sat0, sat1;

  counter_updn_prescale #(.N(N), .MAX(MAX), .PRESCALE(P0)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .dir(dir), .mode(mode), .load(load),
    .din(din), .q(q0), .tick(tick0), .tc(tc0), .sat(sat0)
  );

  counter_updn_prescale #(.N(N), .MAX(MAX), .PRESCALE(P1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .dir(dir), .mode(mode), .load(load),
    .din(din), .q(q1), .tick(tick1), .tc(tc1), .sat(sat1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model, index 0 -> PRESCALE=1, index 1 -> PRESCALE=3
  int m_q[2], m_pre[2], m_tick[2], m_tc[2], m_sat[2];
  int m_p[2] = '{P0, P1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_pre[k] = 0; m_tick[k] = 0; m_tc[k] = 0; m_sat[k] = 0;
    end
  endtask

  // One clock edge worth of the counting rules, in plain arithmetic.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_tick[k] = 0;
      m_tc[k]   = 0;
      if (load) begin
        m_q[k]   = (int'(din) > MAX) ? MAX : int'(din);
        m_pre[k] = 0;
        m_sat[k] = 0;
      end else if (ce) begin
        m_pre[k] = m_pre[k] + 1;
        if (m_pre[k] == m_p[k]) begin
          m_pre[k]  = 0;
          m_tick[k] = 1;
          if (dir) begin
            if (m_q[k] < MAX) begin m_q[k]++; m_sat[k] = 0; end
            else if (!mode)   begin m_q[k] = 0; m_tc[k] = 1; m_sat[k] = 0; end
            else              m_sat[k] = 1;
          end else begin
            if (m_q[k] > 0)   begin m_q[k]--; m_sat[k] = 0; end
            else if (!mode)   begin m_q[k] = MAX; m_tc[k] = 1; m_sat[k] = 0; end
            else              m_sat[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q0"},    32'(q0),    m_q[0]);
    chk({tag, ".tick0"}, 32'(tick0), m_tick[0]);
    chk({tag, ".tc0"},   32'(tc0),   m_tc[0]);
    chk({tag, ".sat0"},  32'(sat0),  m_sat[0]);
    chk({tag, ".q1"},    32'(q1),    m_q[1]);
    chk({tag, ".tick1"}, 32'(tick1), m_tick[1]);
    chk({tag, ".tc1"},   32'(tc1),   m_tc[1]);
    chk({tag, ".sat1"},  32'(sat1),  m_sat[1]);
  endtask

  // driver: called 1 time unit after a rising edge; applies inputs,
  // advances one edge, then checks 1 unit later.
  task automatic cyc(input logic c, input logic d, input logic m,
                     input logic l, input logic [N-1:0] v, input string tag);
    ce = c; dir = d; mode = m; load = l; din = v;
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse entirely between two edges.
  task automatic rst_pulse(input string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    rst = 1'b0;
  endtask

  int exp_seq[5] = '{3, 2, 1, 0, 5};

  initial begin
    rst = 1'b1; ce = 1'b0; dir = 1'b1; mode = 1'b0; load = 1'b0; din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;

    // wrap up-count with PRESCALE=1
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 0, 0, "up_wrap");
      chk("up_wrap.q_const", 32'(q0), (i + 1) % 6);
      chk("up_wrap.tc_const", 32'(tc0), ((i + 1) % 6 == 0) ? 1 : 0);
    end

    // ce=0 freeze
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 0, "freeze");
      chk("freeze.q_const", 32'(q0), 4);
      chk("freeze.tick_const", 32'(tick0), 0);
    end

    // down-count through the wrap
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, "down_wrap");
      chk("down_wrap.q_const", 32'(q0), exp_seq[i]);
      chk("down_wrap.tc_const", 32'(tc0), (exp_seq[i] == 5) ? 1 : 0);
    end

    // saturate at MAX
    load = 1'b1; din = 3'd4; ce = 1'b0;
    cyc(0, 1, 1, 1, 3'd4, "sat_load");
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 0, 0, "sat_up");
      chk("sat_up.q_const", 32'(q0), 5);
      chk("sat_up.sat_const", 32'(sat0), (i == 0) ? 0 : 1);
    end
    cyc(1, 0, 1, 0, 0, "sat_down");
    chk("sat_down.q_const", 32'(q0), 4);
    chk("sat_down.sat_const", 32'(sat0), 0);

    // load clamps; load beats a wrapping step
    cyc(0, 1, 0, 1, 3'd7, "load_clamp");
    chk("load_clamp.q_const", 32'(q0), 5);
    cyc(1, 1, 0, 1, 3'd2, "load_vs_wrap");
    chk("load_vs_wrap.q_const", 32'(q0), 2);
    chk("load_vs_wrap.tc_const", 32'(tc0), 0);

    // PRESCALE=3 cadence with a ce gap
    cyc(0, 1, 0, 1, 3'd0, "pre_load");
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0, 0, 0, "pre3");
      chk("pre3.tick_const", 32'(tick1), (i % 3 == 2) ? 1 : 0);
    end
    cyc(1, 1, 0, 0, 0, "pre3_gap");
    cyc(0, 1, 0, 0, 0, "pre3_gap");
    cyc(0, 1, 0, 0, 0, "pre3_gap");
    cyc(1, 1, 0, 0, 0, "pre3_gap");
    cyc(1, 1, 0, 0, 0, "pre3_gap");
    chk("pre3_gap.q_const", 32'(q1), 3);

    // async reset mid-count: partial prescaler progress is discarded
    cyc(1, 1, 0, 0, 0, "pre_rst");
    rst_pulse("mid_rst");
    cyc(1, 1, 0, 0, 0, "post_rst");
    cyc(1, 1, 0, 0, 0, "post_rst");
    chk("post_rst.q1_hold", 32'(q1), 0);
    cyc(1, 1, 0, 0, 0, "post_rst");
    chk("post_rst.q1_step", 32'(q1), 1);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) rst_pulse("rand_rst");
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0) ? dir : ~dir,
          ($urandom_range(0, 9) != 0) ? mode : ~mode,
          ($urandom_range(0, 15) == 0), N'($urandom_range(0, 7)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_counter_updn_prescale
